// File: rtl/udma_i2s_tx_pkg.sv
// rtl/udma_i2s_tx_pkg.sv - shared types and helpers for the I2S TX serializer
package udma_i2s_tx_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_STOP = 2'd2
  } state_e;

  // Bit counter value for the Philips one-bit delay slot. It never matches N-1.
  localparam logic [5:0] BIT_CNT_DELAY = 6'h3F;

  function automatic logic sel_bit(input logic [31:0] word,
                                   input logic [4:0]  nm1,
                                   input logic [4:0]  idx,
                                   input logic        lsb_first);
    logic [4:0] pos;
    pos = lsb_first ? idx : (nm1 - idx);
    return word[pos];
  endfunction

endpackage

// File: rtl/udma_i2s_tx_clkgen.sv
// rtl/udma_i2s_tx_clkgen.sv - sck divider with rise/fall tick strobes
module udma_i2s_tx_clkgen
  import udma_i2s_tx_pkg::*;
#(
  parameter int unsigned DIV_WIDTH = 16
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 en_i,
  input  logic [DIV_WIDTH-1:0] div_i,
  output logic                 sck_o,
  output logic                 rise_tick_o,
  output logic                 fall_tick_o
);

  logic [DIV_WIDTH-1:0] cnt_q;
  logic                 sck_q;
  logic                 tick;

  assign tick        = en_i & (cnt_q == div_i);
  assign rise_tick_o = tick & ~sck_q;
  assign fall_tick_o = tick & sck_q;
  assign sck_o       = sck_q;

  // Cleared while disabled so the first tick after enable is always a rise.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q <= '0;
      sck_q <= 1'b0;
    end else if (!en_i) begin
      cnt_q <= '0;
      sck_q <= 1'b0;
    end else if (tick) begin
      cnt_q <= '0;
      sck_q <= ~sck_q;
    end else begin
      cnt_q <= cnt_q + DIV_WIDTH'(1);
    end
  end

endmodule

// File: rtl/udma_i2s_tx_serializer.sv
// rtl/udma_i2s_tx_serializer.sv - Philips I2S master transmitter with one-entry holding buffer
module udma_i2s_tx_serializer
  import udma_i2s_tx_pkg::*;
#(
  parameter int unsigned DIV_WIDTH = 16
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 cfg_en_i,
  input  logic [DIV_WIDTH-1:0] cfg_clk_div_i,
  input  logic [4:0]           cfg_bits_word_i,
  input  logic                 cfg_lsb_first_i,
  input  logic                 err_clr_i,
  input  logic [31:0]          data_i,
  input  logic                 data_valid_i,
  output logic                 data_ready_o,
  output logic                 sck_o,
  output logic                 ws_o,
  output logic                 sd_o,
  output logic                 busy_o,
  output logic                 underrun_o
);

  state_e               state_q;
  logic [DIV_WIDTH-1:0] div_q;
  logic [4:0]           nm1_q;
  logic                 lsb_q;
  logic [31:0]          buf_q;
  logic                 buf_full_q;
  logic [31:0]          smp_q;
  logic [5:0]           bit_cnt_q;
  logic                 ch_q;
  logic                 ws_q;
  logic                 sd_q;
  logic                 underrun_q;

  logic                 fall_tick;
  logic                 unused_rise_tick;
  logic                 active;
  logic                 last_bit;
  logic                 in_delay;
  logic                 frame_end;
  logic                 load;
  logic                 accept;
  logic [31:0]          load_word;
  logic [5:0]           bit_cnt_d;
  logic [31:0]          smp_d;
  logic                 sd_d;
  logic                 ws_toggle;

  udma_i2s_tx_clkgen #(
    .DIV_WIDTH (DIV_WIDTH)
  ) u_clkgen (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .en_i        (active),
    .div_i       (div_q),
    .sck_o       (sck_o),
    .rise_tick_o (unused_rise_tick),
    .fall_tick_o (fall_tick)
  );

  assign active   = (state_q != ST_IDLE);
  assign last_bit = (bit_cnt_q == {1'b0, nm1_q});
  assign in_delay = (bit_cnt_q == BIT_CNT_DELAY);

  // The fall tick after a right-channel LSB closes the frame; it does not load.
  assign frame_end = fall_tick & last_bit & ch_q & (state_q == ST_STOP) & ~cfg_en_i;
  assign load      = fall_tick & (in_delay | last_bit) & ~frame_end;
  assign accept    = data_valid_i & data_ready_o;
  assign load_word = buf_full_q ? buf_q : 32'h0;

  assign bit_cnt_d = load ? 6'd0 : (bit_cnt_q + 6'd1);
  assign smp_d     = load ? load_word : smp_q;
  assign sd_d      = sel_bit(smp_d, nm1_q, bit_cnt_d[4:0], lsb_q);
  assign ws_toggle = (bit_cnt_d == {1'b0, nm1_q});

  assign data_ready_o = (state_q == ST_RUN) & ~buf_full_q;
  assign busy_o       = active;
  assign ws_o         = ws_q;
  assign sd_o         = sd_q;
  assign underrun_o   = underrun_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= ST_IDLE;
      div_q      <= '0;
      nm1_q      <= '0;
      lsb_q      <= 1'b0;
      buf_q      <= '0;
      buf_full_q <= 1'b0;
      smp_q      <= '0;
      bit_cnt_q  <= '0;
      ch_q       <= 1'b0;
      ws_q       <= 1'b0;
      sd_q       <= 1'b0;
      underrun_q <= 1'b0;
    end else begin
      // A same-cycle accept refills the slot a load has just drained.
      if (accept) begin
        buf_q      <= data_i;
        buf_full_q <= 1'b1;
      end else if (load) begin
        buf_full_q <= 1'b0;
      end

      if (load && !buf_full_q) begin
        underrun_q <= 1'b1;
      end else if (err_clr_i) begin
        underrun_q <= 1'b0;
      end

      unique case (state_q)
        ST_IDLE: begin
          ws_q <= 1'b0;
          sd_q <= 1'b0;
          if (cfg_en_i) begin
            state_q   <= ST_RUN;
            div_q     <= cfg_clk_div_i;
            nm1_q     <= cfg_bits_word_i;
            lsb_q     <= cfg_lsb_first_i;
            bit_cnt_q <= BIT_CNT_DELAY;
            ch_q      <= 1'b0;
          end
        end
        ST_RUN, ST_STOP: begin
          if (frame_end) begin
            state_q <= ST_IDLE;
            ws_q    <= 1'b0;
            sd_q    <= 1'b0;
          end else begin
            if (state_q == ST_RUN && !cfg_en_i) begin
              state_q <= ST_STOP;
            end else if (state_q == ST_STOP && cfg_en_i) begin
              state_q <= ST_RUN;
            end
            if (fall_tick) begin
              bit_cnt_q <= bit_cnt_d;
              smp_q     <= smp_d;
              sd_q      <= sd_d;
              if (ws_toggle) begin
                ws_q <= ~ws_q;
              end
              // ws already reflects the channel of the sample about to start.
              if (load) begin
                ch_q <= ws_q;
              end
            end
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

endmodule
